clock_display_scan: RTL



---
 rtl/clock_disp_pkg.sv | 35 +++
 rtl/bcd_to_7seg.sv | 34 +++
 rtl/clock_display_scan.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/clock_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_disp_pkg
//  Purpose  : Shared constants for the clock seven-segment display path:
//             active-low segment patterns, slot indices and digit count.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Scan slot order, least significant digit first.
    localparam logic [2:0] SLOT_S1 = 3'd0;
    localparam logic [2:0] SLOT_S2 = 3'd1;
    localparam logic [2:0] SLOT_M1 = 3'd2;
    localparam logic [2:0] SLOT_M2 = 3'd3;
    localparam logic [2:0] SLOT_H1 = 3'd4;
    localparam logic [2:0] SLOT_H2 = 3'd5;

endpackage : clock_disp_pkg
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_7seg
//  Purpose  : Combinational BCD to active-low seven-segment decoder.
//             Codes 10..15 render as a dash (segment g only).
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup; anything outside 0..9 shows a dash.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/clock_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : clock_display_scan
//  Purpose  : Time-multiplexed driver for a 6-digit common-anode display.
//             Snapshots the BCD time once per frame, adds dead time at the
//             start of every slot, per-digit blink, hour-tens blanking and
//             fixed colon decimal points. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    input  logic       blank_lz,
    input  logic [5:0] blink_sel,
    input  logic       blink_phase,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       snap_q [NUM_DIGITS];
    logic             frame_start_q;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_end;
    logic             frame_wrap;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;

    assign slot_end   = (div_q == DIV_W'(REFRESH_DIV - 1));
    assign frame_wrap = slot_end && (idx_q == SLOT_H2);

    // Slot divider and digit index advance.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            div_d = '0;
            idx_d = (idx_q == SLOT_H2) ? SLOT_S1 : idx_q + 3'd1;
        end
    end

    // Scan position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= SLOT_S1;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    // Capture all six digits together at the frame boundary so one frame
    // never mixes old and new time.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_q[i] <= 4'd0;
            end
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_wrap;
            if (frame_wrap) begin
                snap_q[SLOT_S1] <= s1;
                snap_q[SLOT_S2] <= s2;
                snap_q[SLOT_M1] <= m1;
                snap_q[SLOT_M2] <= m2;
                snap_q[SLOT_H1] <= h1;
                snap_q[SLOT_H2] <= h2;
            end
        end
    end

    // Select the snapshot digit for the active slot.
    always_comb begin
        cur_digit = 4'd0;
        case (idx_q)
            SLOT_S1: cur_digit = snap_q[SLOT_S1];
            SLOT_S2: cur_digit = snap_q[SLOT_S2];
            SLOT_M1: cur_digit = snap_q[SLOT_M1];
            SLOT_M2: cur_digit = snap_q[SLOT_M2];
            SLOT_H1: cur_digit = snap_q[SLOT_H1];
            SLOT_H2: cur_digit = snap_q[SLOT_H2];
            default: cur_digit = 4'd0;
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    // Next display value: dead time blanks everything; a dark digit keeps its
    // anode but turns off segments and dp; dp doubles as the colon.
    always_comb begin
        an_d  = 6'b111111;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (div_q >= DIV_W'(DEAD_CYC)) begin
            an_d = ~(6'b000001 << idx_q);
            if (!((blink_sel[idx_q] && blink_phase) ||
                  ((idx_q == SLOT_H2) && blank_lz && (cur_digit == 4'd0)))) begin
                seg_d = cur_seg;
                dp_d  = !((idx_q == SLOT_M1) || (idx_q == SLOT_H1));
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 6'b111111;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule : clock_display_scan
`default_nettype wire
